adder3_checker: RTL
===================

# adder3_checker

Synthesizable, self-checking stimulus/response unit for the 3-input full adder (`Adder3`). It is the driving and checking end of the adder's `SW[2:0]` to `LEDR[1:0]` interface. On a start pulse it steps the adder through all eight input vectors. For each vector it waits a programmable settle time, samples the adder output and compares it with a golden sum. Results go to board LEDs/HEX logic, so the adder can be proven on the FPGA without a simulator.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling; legal range 1..255.
- `CNT_W`, default 4: width of the error counter; must be ≥ 4.

- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a test run; acted on only when `busy`=0.
- `stim` out 3: vector driven to the adder (connects to the adder's `SW`); bit0=a, bit1=b, bit2=cin.
- `resp` in 2: adder output (connects to the adder's `LEDR`); bit1=carry, bit0=sum.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until the next accepted `start` or `rst`.
- `pass` out 1: valid while `done`=1; high iff `err_count`=0.
- `err_count` out CNT_W: number of mismatching vectors in the last run; saturating.
- `fail_vec` out 3: `stim` value of the first mismatch.
- `fail_resp` out 2: `resp` value captured at the first mismatch.

## Operation
- The FSM has four states: IDLE, SETTLE, CHECK and DONE. There is an internal 3-bit vector index `vec` and a settle counter `scnt`.
- **Reset**, in any state including mid-run:
  - state returns to IDLE, `vec`=0.
  - `stim`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `fail_vec`=0, `fail_resp`=0.
- **IDLE or DONE with `start`=1:**
  - clears `err_count`, `fail_vec`, `fail_resp`, `done` and `pass`.
  - sets `vec`=0, `scnt`=SETTLE_CYCLES-1 and `busy`=1, then enters SETTLE.
- **SETTLE:**
  - `stim` is driven from registered `vec`.
  - `scnt` decrements each cycle; when `scnt`=0 the FSM moves to CHECK.
- **CHECK** (one cycle):
  - expected value = zero-extended `stim[0]+stim[1]+stim[2]`, 2 bits, no overflow possible.
  - On mismatch, `err_count` increments, saturating at 2^CNT_W-1.
  - If this is the first mismatch (`err_count` was 0), `fail_vec` and `fail_resp` are captured.
  - If `vec`=7, go to DONE. Otherwise increment `vec`, reload `scnt`, and return to SETTLE.
- **DONE:**
  - `busy`=0, `done`=1, `pass`=(`err_count`==0).
  - `stim` holds its last vector (7).
- `start` asserted while `busy`=1 is ignored and has no side effects.
- `resp` is sampled only in CHECK. Its value in every other state is don't-care.

## Timing
- Call the cycle in which `start` is sampled high cycle 0. From cycle 1 onward:
  - `busy`=1 and `stim`=0.
  - Vector k is driven during cycles 1+k·(S+1) through (k+1)·(S+1), where S=SETTLE_CYCLES.
  - Vector k is checked in cycle (k+1)·(S+1).
- `stim` changes only on the edge leaving CHECK, so each vector is stable for exactly S+1 cycles.
- `done` rises, and `busy` falls, in cycle 8·(S+1)+1. With the default S=4 this is cycle 41.
- `err_count` and `fail_*` update on the edge ending the CHECK cycle, visible the next cycle.
- A restart from DONE behaves identically to a start from IDLE: `done` drops in cycle 1.

## Configuration
- Macro: `ADDER3_CHECKER_STOP_ON_FAIL_EN`.
- **Defined:** CHECK with a mismatch goes directly to DONE after recording the error.
  - `err_count` is then at most 1.
  - `stim` holds the failing vector, for probing on the board.
- **Undefined (default):** all eight vectors are always exercised, and `err_count` reports the total number of failures.

## Test plan
- Reset, then `start` with a correct adder model (S=4): `stim` steps 0..7, five cycles each. `done`=1 and `busy`=0 at cycle 41; `pass`=1, `err_count`=0.
- Adder model with carry stuck at 0: `err_count`=4 (vectors 3, 5, 6, 7), `pass`=0, `fail_vec`=3, `fail_resp`=2'b00.
- Adder model with sum output inverted: `err_count`=8, `fail_vec`=0, `fail_resp`=2'b01.
- Pulse `start` again at cycle 20 of a run: no restart; `done` still rises at cycle 41 with unchanged results.
- Assert `rst` at cycle 17 of a run with the faulty carry: all outputs are 0 in the following cycle and the FSM is in IDLE. A fresh `start` then completes normally.
- With `ADDER3_CHECKER_STOP_ON_FAIL_EN` and carry stuck at 0: `done` rises one cycle after vector 3's check (cycle 21). `err_count`=1 and `stim` holds 3.

Source files
------------

// File: rtl/adder3_checker.sv
// Stimulus/response checker for a 3-input full adder: walks all eight input vectors and compares the response with a golden sum.
// Optional macro ADDER3_CHECKER_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module adder3_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [2:0]       stim,
  input  logic [1:0]       resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       fail_vec,
  output logic [1:0]       fail_resp
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0]       SCNT_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t     state, state_nxt;
  logic [2:0] vec;
  logic [7:0] scnt;
  logic [1:0] expected;
  logic       mismatch;

  // stim is a direct view of the vector register, so it only moves when vec does.
  assign stim = vec;
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    expected  = {1'b0, vec[0]} + {1'b0, vec[1]} + {1'b0, vec[2]};
    mismatch  = (resp != expected);
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SETTLE;
      SETTLE:     if (scnt == 8'd0) state_nxt = CHECK;
      CHECK: begin
`ifdef ADDER3_CHECKER_STOP_ON_FAIL_EN
        if (mismatch || vec == 3'd7) state_nxt = DONE;
        else                         state_nxt = SETTLE;
`else
        if (vec == 3'd7) state_nxt = DONE;
        else             state_nxt = SETTLE;
`endif
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= 3'd0;
      scnt      <= 8'd0;
      err_count <= '0;
      fail_vec  <= 3'd0;
      fail_resp <= 2'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= 3'd0;
            scnt      <= SCNT_LOAD;
            err_count <= '0;
            fail_vec  <= 3'd0;
            fail_resp <= 2'd0;
          end
        end
        SETTLE: begin
          if (scnt != 8'd0) scnt <= scnt - 8'd1;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + CNT_ONE;
            // Only the first failure of a run is recorded for diagnosis.
            if (err_count == '0) begin
              fail_vec  <= vec;
              fail_resp <= resp;
            end
          end
          if (state_nxt == SETTLE) begin
            vec  <= vec + 3'd1;
            scnt <= SCNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
